cp0_unit: RTL and testbench

Parametrised CP0 system-control block for the pipelined MIPS core, sitting beside the MEM/WB boundary where exceptions are committed. It holds Count, Compare, Status, Cause, EPC, BadVAddr, PRId and Config. It performs precise exception entry and ERET return, and generates a masked interrupt request and pipeline redirect. This version adds the following, with width and placement set by parameters:
- Configurable interrupt-line count.
- Count prescaler.
- Status.IM masking.
- EXL-nested exception handling.

---
 rtl/cp0_unit.sv | 198 +++++++++++++++++++
 tb/tb_cp0_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor-0 system control beside the MEM/WB commit point.
// Holds Count/Compare/Status/Cause/EPC/BadVAddr/PRId/Config, performs precise
// exception entry (with EXL nesting) and ERET, and raises a masked interrupt
// request plus the pipeline redirect.
module cp0_unit #(
  parameter int          HW_INT_NUM   = 6,
  parameter int          TIMER_IP     = 7,
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [31:0]           wdata,
  input  logic [4:0]            raddr,
  output logic [31:0]           rdata,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  output logic                  int_req,
  output logic                  flush,
  output logic [31:0]           flush_pc,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  ti_q, ti_d;
  logic [7:0]            im_q, im_d;
  logic                  exl_q, exl_d;
  logic                  ie_q, ie_d;
  logic                  bd_q, bd_d;
  logic [1:0]            ip_sw_q, ip_sw_d;
  logic [4:0]            exccode_q, exccode_d;
  logic [31:0]           epc_q, epc_d;
  logic [31:0]           badvaddr_q, badvaddr_d;
  logic [HW_INT_NUM-1:0] hw_int_q;

  logic [7:0]  ip;
  logic [31:0] status_val;
  logic [31:0] cause_val;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  assign wr_count   = we && (waddr == REG_COUNT);
  assign wr_compare = we && (waddr == REG_COMPARE);
  assign wr_status  = we && (waddr == REG_STATUS);
  assign wr_cause   = we && (waddr == REG_CAUSE);
  assign wr_epc     = we && (waddr == REG_EPC);

  // Assemble Cause.IP from sampled hardware lines, the timer flag and the software bits.
  always_comb begin
    ip = {6'b0, ip_sw_q};
    for (int i = 0; i < HW_INT_NUM; i++) begin
      ip[2+i] = hw_int_q[i];
    end
    ip[TIMER_IP] = ip[TIMER_IP] | ti_q;
  end

  assign status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_val  = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};

  assign status_o = status_val;
  assign cause_o  = cause_val;
  assign epc_o    = epc_q;

  assign int_req  = ie_q & ~exl_q & (|(ip & im_q));
  assign flush    = exc_valid | eret;
  // Idle default is the vector so the redirect target is stable out of reset.
  assign flush_pc = (eret && !exc_valid) ? epc_q : EXC_VECTOR;

  // MFC0 read mux over pre-edge state.
  always_comb begin
    rdata = 32'b0;
    case (raddr)
      REG_BADVADDR: rdata = badvaddr_q;
      REG_COUNT:    rdata = count_q;
      REG_COMPARE:  rdata = compare_q;
      REG_STATUS:   rdata = status_val;
      REG_CAUSE:    rdata = cause_val;
      REG_EPC:      rdata = epc_q;
      REG_PRID:     rdata = PRID_VALUE;
      REG_CONFIG:   rdata = CONFIG_VALUE;
      default:      rdata = 32'b0;
    endcase
  end

  // Next-state: timer, MTC0 writes, then exception/ERET overriding the fields they own.
  always_comb begin
    count_d    = count_q;
    compare_d  = compare_q;
    div_d      = div_q;
    ti_d       = ti_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    if (wr_count) begin
      count_d = wdata;
      div_d   = '0;
    end else if (div_q == DIV_LAST) begin
      div_d   = '0;
      count_d = count_q + 32'd1;
    end else begin
      div_d   = div_q + DIV_W'(1);
    end

    if (wr_compare) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d      = 1'b1;
    end

    if (wr_status) begin
      im_d  = wdata[15:8];
      exl_d = wdata[1];
      ie_d  = wdata[0];
    end
    if (wr_cause) ip_sw_d = wdata[9:8];
    if (wr_epc)   epc_d   = wdata;

    if (exc_valid) begin
      exccode_d = exc_code;
      exl_d     = 1'b1;
      // A nested exception keeps the outer return point.
      if (!exl_q) begin
        epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
        bd_d  = exc_bd;
      end else begin
        epc_d = epc_q;
      end
      if (exc_code == 5'd4 || exc_code == 5'd5) badvaddr_d = exc_badvaddr;
    end else if (eret) begin
      exl_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      compare_q  <= '0;
      div_q      <= '0;
      ti_q       <= 1'b0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_sw_q    <= '0;
      exccode_q  <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      hw_int_q   <= '0;
    end else begin
      count_q    <= count_d;
      compare_q  <= compare_d;
      div_q      <= div_d;
      ti_q       <= ti_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      hw_int_q   <= hw_int;
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: register read/write table plus timer, exception and
// interrupt sequences, all with hand-computed expectations.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [5:0]  hw_int;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic        int_req;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] status_o, cause_o, epc_o;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_unit dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .hw_int(hw_int),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr), .eret(eret),
    .int_req(int_req), .flush(flush), .flush_pc(flush_pc),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input string name, input logic [31:0] exp);
    raddr = a;
    #1;
    check(name, rdata, exp);
  endtask

  initial begin
    logic [31:0] c0;
    logic        seen;

    vecs[0]  = '{1'b1, 5'd11, 32'hFFFF0000, 5'd11, 32'hFFFF0000, "compare_rw"};
    vecs[1]  = '{1'b1, 5'd13, 32'hFFFFFFFF, 5'd13, 32'h00000300, "cause_mask"};
    vecs[2]  = '{1'b1, 5'd13, 32'h00000000, 5'd13, 32'h00000000, "cause_clr"};
    vecs[3]  = '{1'b1, 5'd12, 32'hFFFFFFFF, 5'd12, 32'h0040FF03, "status_mask"};
    vecs[4]  = '{1'b1, 5'd12, 32'h00000000, 5'd12, 32'h00400000, "status_clr"};
    vecs[5]  = '{1'b1, 5'd14, 32'hDEADBEEF, 5'd14, 32'hDEADBEEF, "epc_rw"};
    vecs[6]  = '{1'b1, 5'd8,  32'h00000055, 5'd8,  32'h00000000, "badvaddr_ro"};
    vecs[7]  = '{1'b1, 5'd15, 32'h00000000, 5'd15, 32'h004C0102, "prid"};
    vecs[8]  = '{1'b1, 5'd16, 32'h00000000, 5'd16, 32'h00008000, "config"};
    vecs[9]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 32'h00000000, "unmapped"};
    vecs[10] = '{1'b1, 5'd9,  32'h00000100, 5'd9,  32'h00000100, "count_load"};
    vecs[11] = '{1'b0, 5'd0,  32'h00000000, 5'd3,  32'h00000000, "reg3_zero"};

    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = 5'd9;
    hw_int = '0; exc_valid = 1'b0; exc_code = '0; exc_pc = '0;
    exc_bd = 1'b0; exc_badvaddr = '0; eret = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_status", status_o, 32'h00400000);
    check("rst_cause", cause_o, 32'h0);
    check("rst_epc", epc_o, 32'h0);
    check("rst_intreq", {31'b0, int_req}, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_flush_pc", flush_pc, 32'hBFC00380);
    rd(5'd9, "rst_count", 32'h0);

    // Test 1: ten idle cycles at COUNT_DIV=2
    rst = 1'b0;
    repeat (10) tick();
    rd(5'd9, "idle_count", 32'd5);
    check("idle_status", status_o, 32'h00400000);
    check("idle_intreq", {31'b0, int_req}, 32'h0);
    rd(5'd3, "idle_reg3", 32'h0);

    // Register table
    foreach (vecs[i]) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      raddr = vecs[i].raddr;
      tick();
      we = 1'b0;
      #1;
      check(vecs[i].name, rdata, vecs[i].exp);
    end

    // Test 2: timer compare
    mtc0(5'd11, 32'd8);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h00008001);
    raddr = 5'd9;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      seen = cause_o[30];
    end
    check("ti_seen", {31'b0, seen}, 32'h1);
    rd(5'd9, "ti_count_at_set", 32'd8);
    check("ti_ip7", {31'b0, cause_o[15]}, 32'h1);
    check("ti_intreq", {31'b0, int_req}, 32'h1);
    tick();
    check("ti_sticky", {31'b0, cause_o[30]}, 32'h1);
    mtc0(5'd11, 32'd20);
    check("ti_clear", {31'b0, cause_o[30]}, 32'h0);
    check("ti_clear_intreq", {31'b0, int_req}, 32'h0);

    // Test 3: exception entry from a delay slot
    exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h80001004;
    exc_bd = 1'b1; exc_badvaddr = 32'h13;
    #1;
    check("exc_flush", {31'b0, flush}, 32'h1);
    check("exc_flush_pc", flush_pc, 32'hBFC00380);
    tick();
    exc_valid = 1'b0;
    check("exc_epc", epc_o, 32'h80001000);
    check("exc_bd", {31'b0, cause_o[31]}, 32'h1);
    check("exc_code", {27'b0, cause_o[6:2]}, 32'd4);
    check("exc_exl", {31'b0, status_o[1]}, 32'h1);
    rd(5'd8, "exc_badvaddr", 32'h13);

    // Test 4: nested exception, then ERET
    exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h80002000;
    exc_bd = 1'b0; exc_badvaddr = 32'h99;
    tick();
    exc_valid = 1'b0;
    check("nest_epc", epc_o, 32'h80001000);
    check("nest_bd", {31'b0, cause_o[31]}, 32'h1);
    check("nest_code", {27'b0, cause_o[6:2]}, 32'd8);
    rd(5'd8, "nest_badvaddr_kept", 32'h13);
    eret = 1'b1;
    #1;
    check("eret_flush", {31'b0, flush}, 32'h1);
    check("eret_flush_pc", flush_pc, 32'h80001000);
    tick();
    eret = 1'b0;
    check("eret_exl", {31'b0, status_o[1]}, 32'h0);

    // Test 5: hardware interrupt masking
    mtc0(5'd12, 32'h00000401);
    hw_int = 6'b000001;
    #1;
    check("hw_int_latency", {31'b0, int_req}, 32'h0);
    tick();
    check("hw_int_req", {31'b0, int_req}, 32'h1);
    check("hw_int_ip2", {31'b0, cause_o[10]}, 32'h1);
    mtc0(5'd12, 32'h00000403);
    check("hw_int_exl_mask", {31'b0, int_req}, 32'h0);
    hw_int = '0;

    // exc_valid beats a same-cycle eret
    mtc0(5'd12, 32'h00000001);
    exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h80003000; exc_bd = 1'b0;
    eret = 1'b1;
    #1;
    check("prio_flush_pc", flush_pc, 32'hBFC00380);
    tick();
    exc_valid = 1'b0; eret = 1'b0;
    check("prio_exl", {31'b0, status_o[1]}, 32'h1);
    check("prio_epc", epc_o, 32'h80003000);

    // Test 6: exception beats MTC0 EPC in the same cycle
    mtc0(5'd12, 32'h00000001);
    exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h80004000; exc_bd = 1'b0;
    we = 1'b1; waddr = 5'd14; wdata = 32'h1234;
    tick();
    exc_valid = 1'b0; we = 1'b0;
    check("exc_vs_mtc0_epc", epc_o, 32'h80004000);

    // MTC0 Count on a tick cycle, then wrap
    raddr = 5'd9;
    #1;
    c0 = rdata;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      seen = (rdata != c0);
    end
    check("count_moving", {31'b0, seen}, 32'h1);
    tick();
    mtc0(5'd9, 32'hFFFFFFFF);
    rd(5'd9, "count_load_beats_tick", 32'hFFFFFFFF);
    tick();
    rd(5'd9, "count_hold", 32'hFFFFFFFF);
    tick();
    rd(5'd9, "count_wrap", 32'h0);

    // Reset in the middle of activity
    rst = 1'b1; we = 1'b1; waddr = 5'd14; wdata = 32'hCAFEF00D;
    exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h1000;
    tick();
    rst = 1'b0; we = 1'b0; exc_valid = 1'b0;
    check("midrst_epc", epc_o, 32'h0);
    check("midrst_status", status_o, 32'h00400000);
    rd(5'd8, "midrst_badvaddr", 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
